// File: rtl/tile_spawner.sv
// Falling-tile spawner: drops tiles onto eight tracks at a fixed period, picking a
// pseudo-random free track, and scores each tile as a hit (erase) or a miss.
module tile_spawner #(
    parameter logic [31:0] SPAWN_EASY = 32'd100000000,
    parameter logic [31:0] SPAWN_HARD = 32'd50000000,
    parameter logic [31:0] FALL_EASY  = 32'd250000000,
    parameter logic [31:0] FALL_HARD  = 32'd125000000,
    parameter logic [2:0]  LIVES      = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        level,
    input  logic [7:0]  erase,
    output logic [7:0]  v_enb,
    output logic [7:0]  miss,
    output logic [2:0]  lives,
    output logic        game_over,
    output logic [15:0] spawn_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StOver} top_state_e;
    typedef enum logic [1:0] {TrkFree, TrkFalling, TrkCool} trk_state_e;

    top_state_e  state_q, state_d;
    trk_state_e  trk_q [8];
    trk_state_e  trk_d [8];
    logic [31:0] fall_q [8];
    logic [31:0] fall_d [8];
    logic        level_q, level_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  v_enb_q, v_enb_d;
    logic [7:0]  miss_q, miss_d;
    logic [2:0]  lives_q, lives_d;
    logic [15:0] spawn_cnt_q, spawn_cnt_d;

    logic        active;
    logic        spawn_ev;
    logic        spawn_hit;
    logic [2:0]  spawn_trk;
    logic [2:0]  scan_idx;
    logic [3:0]  miss_cnt;
    logic [31:0] spawn_period;
    logic [31:0] fall_period;

    assign spawn_period = level_q ? SPAWN_HARD : SPAWN_EASY;
    assign fall_period  = level_q ? FALL_HARD : FALL_EASY;
    // The cycle in RUN with no lives left is the handover to OVER: tracks are dropped.
    assign active = (state_q == StRun) && (lives_q != 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (lives_q == 3'd0) state_d = StOver;
            StOver:  state_d = StOver;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        game_over = (state_q == StOver);
        v_enb     = v_enb_q;
        miss      = miss_q;
        lives     = lives_q;
        spawn_cnt = spawn_cnt_q;
    end

    always_comb begin
        level_d     = level_q;
        lfsr_d      = lfsr_q;
        timer_d     = timer_q;
        lives_d     = lives_q;
        spawn_cnt_d = spawn_cnt_q;
        v_enb_d     = '0;
        miss_d      = '0;
        spawn_ev    = 1'b0;
        spawn_hit   = 1'b0;
        spawn_trk   = '0;
        scan_idx    = '0;
        miss_cnt    = '0;
        for (int i = 0; i < 8; i++) begin
            trk_d[i]  = TrkFree;
            fall_d[i] = '0;
        end

        if (state_q == StIdle && start) level_d = level;
        if (state_q == StRun) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        if (active) begin
            spawn_ev = (timer_q == spawn_period - 32'd1);
            timer_d  = spawn_ev ? '0 : timer_q + 32'd1;
            for (int k = 0; k < 8; k++) begin
                scan_idx = lfsr_q[2:0] + 3'(k);
                if (!spawn_hit && trk_q[scan_idx] == TrkFree) begin
                    spawn_hit = 1'b1;
                    spawn_trk = scan_idx;
                end
            end

            for (int i = 0; i < 8; i++) begin
                trk_d[i]  = trk_q[i];
                fall_d[i] = fall_q[i];
                case (trk_q[i])
                    TrkFree: begin
                        if (spawn_ev && spawn_hit && spawn_trk == 3'(i)) begin
                            trk_d[i]  = TrkFalling;
                            fall_d[i] = '0;
                        end
                    end
                    TrkFalling: begin
                        fall_d[i] = fall_q[i] + 32'd1;
                        // Early erase flags are stale hits from the previous tile.
                        if (erase[i] && fall_q[i] >= 32'd2) begin
                            trk_d[i] = TrkCool;
                        end else if (fall_q[i] == fall_period - 32'd1) begin
                            trk_d[i]  = TrkCool;
                            miss_d[i] = 1'b1;
                        end
                    end
                    TrkCool: trk_d[i] = TrkFree;
                    default: trk_d[i] = TrkFree;
                endcase
                v_enb_d[i] = (trk_d[i] == TrkFalling);
                miss_cnt   = miss_cnt + {3'd0, miss_d[i]};
            end

            if (spawn_ev && spawn_hit) spawn_cnt_d = spawn_cnt_q + 16'd1;
            if ({1'b0, lives_q} <= miss_cnt) begin
                lives_d = '0;
            end else begin
                lives_d = lives_q - miss_cnt[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q     <= 1'b0;
            lfsr_q      <= 16'hACE1;
            timer_q     <= '0;
            v_enb_q     <= '0;
            miss_q      <= '0;
            lives_q     <= LIVES;
            spawn_cnt_q <= '0;
            for (int i = 0; i < 8; i++) begin
                trk_q[i]  <= TrkFree;
                fall_q[i] <= '0;
            end
        end else begin
            level_q     <= level_d;
            lfsr_q      <= lfsr_d;
            timer_q     <= timer_d;
            v_enb_q     <= v_enb_d;
            miss_q      <= miss_d;
            lives_q     <= lives_d;
            spawn_cnt_q <= spawn_cnt_d;
            for (int i = 0; i < 8; i++) begin
                trk_q[i]  <= trk_d[i];
                fall_q[i] <= fall_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Bench for tile_spawner: two instances (small periods, and a dense one that can fill all
// tracks) driven by shared stimulus and compared every cycle against an event-level model.
module tb_tile_spawner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       level;
    logic [7:0] erase;

    logic [7:0]  v_enb_w [2];
    logic [7:0]  miss_w  [2];
    logic [2:0]  lives_w [2];
    logic        go_w    [2];
    logic [15:0] cnt_w   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tile_spawner #(
        .SPAWN_EASY(32'd8), .SPAWN_HARD(32'd4), .FALL_EASY(32'd20), .FALL_HARD(32'd10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .level(level), .erase(erase),
        .v_enb(v_enb_w[0]), .miss(miss_w[0]), .lives(lives_w[0]), .game_over(go_w[0]),
        .spawn_cnt(cnt_w[0])
    );

    tile_spawner #(
        .SPAWN_EASY(32'd2), .SPAWN_HARD(32'd2), .FALL_EASY(32'd24), .FALL_HARD(32'd24)
    ) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .level(level), .erase(erase),
        .v_enb(v_enb_w[1]), .miss(miss_w[1]), .lives(lives_w[1]), .game_over(go_w[1]),
        .spawn_cnt(cnt_w[1])
    );

    // Model: phase 0 idle, 1 run, 2 over; tiles tracked by birth cycle and free-again cycle.
    int          m_phase [2];
    bit          m_lvl   [2];
    int          m_cyc   [2];
    logic [15:0] m_lfsr  [2];
    bit          m_on    [2][8];
    int          m_born  [2][8];
    int          m_free  [2][8];
    logic [7:0]  m_venb  [2];
    logic [7:0]  m_miss  [2];
    int          m_lives [2];
    logic [15:0] m_cnt   [2];

    function automatic int spawn_per(input int i, input bit lv);
        if (i == 1) return 2;
        return lv ? 4 : 8;
    endfunction

    function automatic int fall_per(input int i, input bit lv);
        if (i == 1) return 24;
        return lv ? 10 : 20;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge(input int i);
        int pick;
        int nmiss;
        int age;
        int t;
        m_miss[i] = '0;
        if (!rst_n) begin
            m_phase[i] = 0;
            m_lives[i] = 3;
            m_cnt[i]   = '0;
            m_venb[i]  = '0;
            m_lfsr[i]  = 16'hACE1;
            for (int k = 0; k < 8; k++) begin
                m_on[i][k]   = 1'b0;
                m_free[i][k] = 0;
            end
            return;
        end
        if (m_phase[i] == 0) begin
            if (start) begin
                m_phase[i] = 1;
                m_lvl[i]   = level;
                m_cyc[i]   = 0;
            end
        end else if (m_phase[i] == 1) begin
            if (m_lives[i] == 0) begin
                m_phase[i] = 2;
                m_venb[i]  = '0;
                for (int k = 0; k < 8; k++) m_on[i][k] = 1'b0;
            end else begin
                pick = -1;
                if ((m_cyc[i] + 1) % spawn_per(i, m_lvl[i]) == 0) begin
                    for (int k = 0; k < 8; k++) begin
                        t = (int'(m_lfsr[i][2:0]) + k) % 8;
                        if (pick < 0 && !m_on[i][t] && m_cyc[i] >= m_free[i][t]) pick = t;
                    end
                end
                nmiss = 0;
                for (int k = 0; k < 8; k++) begin
                    if (m_on[i][k]) begin
                        age = m_cyc[i] - m_born[i][k];
                        if (age >= 2 && erase[k]) begin
                            m_on[i][k]   = 1'b0;
                            m_free[i][k] = m_cyc[i] + 2;
                        end else if (age == fall_per(i, m_lvl[i]) - 1) begin
                            m_on[i][k]   = 1'b0;
                            m_miss[i][k] = 1'b1;
                            m_free[i][k] = m_cyc[i] + 2;
                            nmiss++;
                        end
                    end
                end
                if (pick >= 0) begin
                    m_on[i][pick]   = 1'b1;
                    m_born[i][pick] = m_cyc[i] + 1;
                    m_cnt[i]        = m_cnt[i] + 16'd1;
                end
                m_lives[i] = (m_lives[i] > nmiss) ? m_lives[i] - nmiss : 0;
                for (int k = 0; k < 8; k++) m_venb[i][k] = m_on[i][k];
                m_lfsr[i] = {m_lfsr[i][14:0],
                             m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
                m_cyc[i]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d v_enb", i), 32'(v_enb_w[i]), 32'(m_venb[i]));
            check($sformatf("u%0d miss", i), 32'(miss_w[i]), 32'(m_miss[i]));
            check($sformatf("u%0d lives", i), 32'(lives_w[i]), 32'(m_lives[i]));
            check($sformatf("u%0d game_over", i), 32'(go_w[i]), (m_phase[i] == 2) ? 32'd1 : 32'd0);
            check($sformatf("u%0d spawn_cnt", i), 32'(cnt_w[i]), 32'(m_cnt[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] coinc_erase();
        logic [7:0] e;
        e = '0;
        for (int k = 0; k < 8; k++) begin
            if (m_phase[0] == 1 && m_on[0][k] &&
                m_cyc[0] - m_born[0][k] == fall_per(0, m_lvl[0]) - 1) e[k] = 1'b1;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        erase = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int steps;
        int hi;
        int trk;
        bit found;

        rst_n = 1'b0;
        start = 1'b0;
        level = 1'b0;
        erase = '0;
        repeat (3) step();
        check("reset lives", 32'(lives_w[0]), 32'd3);
        check("reset v_enb", 32'(v_enb_w[0]), 32'd0);
        check("reset spawn_cnt", 32'(cnt_w[0]), 32'd0);
        rst_n = 1'b1;

        // Easy level, no erase: first tile, full fall window, miss pulse.
        level = 1'b0;
        start = 1'b1;
        steps = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            steps++;
            if (v_enb_w[0] != 0) found = 1'b1;
        end
        check("first rise delay", 32'(steps), 32'd9);
        trk = 0;
        for (int k = 7; k >= 0; k--) if (v_enb_w[0][k]) trk = k;
        hi = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!v_enb_w[0][trk]) break;
            hi++;
        end
        check("fall length", 32'(hi), 32'd20);
        check("miss pulse", 32'(miss_w[0][trk]), 32'd1);
        check("lives after miss", 32'(lives_w[0]), 32'd2);
        step();
        check("miss one cycle", 32'(miss_w[0][trk]), 32'd0);

        // Reset mid-run with tiles falling, then stay idle.
        rst_n = 1'b0;
        step();
        check("midrun rst v_enb", 32'(v_enb_w[0]), 32'd0);
        check("midrun rst lives", 32'(lives_w[0]), 32'd3);
        check("midrun rst cnt", 32'(cnt_w[0]), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) step();
        check("idle no spawn", 32'(cnt_w[0]), 32'd0);

        // Erase held high: each tile is hit as soon as stale hits are ignored.
        erase = 8'hFF;
        start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (v_enb_w[0] != 0) found = 1'b1;
        end
        trk = 0;
        for (int k = 7; k >= 0; k--) if (v_enb_w[0][k]) trk = k;
        hi = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!v_enb_w[0][trk]) break;
            hi++;
        end
        check("hit length", 32'(hi), 32'd3);
        repeat (30) step();
        check("erase lives", 32'(lives_w[0]), 32'd3);

        // Erase only on each tile's final fall cycle: hit wins over miss.
        do_reset();
        start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            erase = coinc_erase();
            step();
        end
        check("coincide lives", 32'(lives_w[0]), 32'd3);

        // Hard level, level input dropped after start, no erase: run out of lives.
        do_reset();
        level = 1'b1;
        start = 1'b1;
        steps = 0;
        for (int k = 0; k < 60 && (steps == 0 || lives_w[0] != 0); k++) begin
            step();
            level = 1'b0;
            steps++;
        end
        check("lives zero cycle", 32'(steps), 32'd23);
        step();
        check("over game_over", 32'(go_w[0]), 32'd1);
        check("over v_enb", 32'(v_enb_w[0]), 32'd0);
        repeat (10) step();
        check("over spawn_cnt frozen", 32'(cnt_w[0]), 32'd5);

        // Dense instance: all eight tracks busy, next spawn skipped.
        do_reset();
        start = 1'b1;
        step();
        repeat (16) step();
        check("full v_enb", 32'(v_enb_w[1]), 32'hFF);
        check("full spawn_cnt", 32'(cnt_w[1]), 32'd8);
        repeat (2) step();
        check("skip spawn_cnt", 32'(cnt_w[1]), 32'd8);
        repeat (20) step();

        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            level = 1'($urandom);
            repeat ($urandom_range(0, 3)) step();
            start = 1'b1;
            for (int c = 0; c < 130; c++) begin
                erase = 8'($urandom) & 8'($urandom) & 8'($urandom);
                if ($urandom_range(0, 9) == 0) level = ~level;
                if ($urandom_range(0, 9) == 0) start = ~start;
                rst_n = ($urandom_range(0, 199) != 0);
                step();
            end
            rst_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_spawner.md
TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 SHALL have parameter SPAWN_EASY, default 32'd100000000, spawn interval in clk cycles when level=0.
REQ-002 SHALL have parameter SPAWN_HARD, default 32'd50000000, spawn interval in clk cycles when level=1.
REQ-003 SHALL have parameter FALL_EASY, default 32'd250000000, tile fall window in cycles when level=0.
REQ-004 SHALL have parameter FALL_HARD, default 32'd125000000, tile fall window in cycles when level=1.
REQ-005 SHALL have parameter LIVES, default 3'd3, starting lives.
REQ-006 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  input  1  level-sensitive game start request.
REQ-009 SHALL have port level  input  1  difficulty, 0 easy, 1 hard.
REQ-010 SHALL have port erase  input  8  per-track tile hit flags from the erase stage.
REQ-011 SHALL have port v_enb  output  8  registered per-track tile-present enables to the erase stage.
REQ-012 SHALL have port miss  output  8  registered one-cycle per-track miss pulses.
REQ-013 SHALL have port lives  output  3  remaining lives.
REQ-014 SHALL have port game_over  output  1  high in OVER state.
REQ-015 SHALL have port spawn_cnt  output  16  tiles spawned since start, wraps 16'hFFFF->0.

Function
REQ-016 SHALL implement top FSM IDLE, RUN, OVER: IDLE->RUN when start=1; RUN->OVER the cycle after lives becomes 0; OVER held until reset.
REQ-017 SHALL latch level on the IDLE->RUN transition; level changes during RUN are ignored.
REQ-018 SHALL keep a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every RUN cycle, never all-zero.
REQ-019 SHALL count a spawn timer 0..period-1 in RUN; first spawn event on the cycle the timer equals period-1, i.e. period cycles after entering RUN, then every period cycles.
REQ-020 SHALL, on a spawn event, pick the first FREE track scanning from lfsr[2:0] upward, wrapping 7->0; if no track is FREE the spawn is skipped and spawn_cnt unchanged.
REQ-021 SHALL give each track its own FSM FREE, FALLING, COOL and a 32-bit fall counter.
REQ-022 SHALL on spawn move the track FREE->FALLING, set v_enb[t]=1 on the next edge, clear its fall counter, increment spawn_cnt.
REQ-023 SHALL in FALLING increment the fall counter each cycle and ignore erase[t] while counter<2, since the erase stage clears stale hits two cycles after the v_enb rising edge.
REQ-024 SHALL in FALLING with counter>=2 and erase[t]=1 record a hit: v_enb[t]=0 next edge, track ->COOL, no miss.
REQ-025 SHALL in FALLING when counter=fall_period-1 and no hit that cycle record a miss: v_enb[t]=0, miss[t]=1 for one cycle, track ->COOL.
REQ-026 SHALL give hit priority over miss when both apply in the same cycle.
REQ-027 SHALL hold COOL exactly one cycle with v_enb[t]=0, then ->FREE, guaranteeing a fresh rising edge for each new tile.
REQ-028 SHALL decrement lives by the number of simultaneous misses, saturating at 0.
REQ-029 SHALL in IDLE and OVER hold v_enb=0, miss=0, timers stopped; tracks falling on entry to OVER are dropped without miss.

Reset
REQ-030 SHALL on rst_n=0 at a clock edge enter IDLE and set v_enb=0, miss=0, lives=LIVES, game_over=0, spawn_cnt=0, LFSR=16'hACE1, all tracks FREE, all counters 0, regardless of prior state.

Verification (SPAWN_EASY=8, SPAWN_HARD=4, FALL_EASY=20, FALL_HARD=10)
REQ-031 SHALL verify start=1,level=0, no erase -> first tile v_enb rises 9 cycles after start, tile falls 20 cycles, miss pulse one cycle, lives 3->2.
REQ-032 SHALL verify erase[t]=1 held from v_enb rise -> ignored for 2 cycles, v_enb[t] drops at counter 2, no miss, lives stays 3.
REQ-033 SHALL verify erase[t] and final fall cycle coincide -> hit, miss[t]=0.
REQ-034 SHALL verify level=1, no erase -> lives reach 0, game_over=1 next cycle, v_enb=0, spawn_cnt frozen.
REQ-035 SHALL verify all 8 tracks FALLING at a spawn event -> spawn skipped, spawn_cnt unchanged; freed track shows v_enb low ≥1 cycle before reuse.
REQ-036 SHALL verify rst_n=0 mid-RUN with tiles falling -> next edge all outputs at reset values, lives=3, FSM IDLE.
